// File: rtl/hall_sequence_generator.sv
// Hall sensor code generator: walks the six legal hall states at a programmable rate or on demand,
// in either direction, with a signed position count and an optional forced 3'b111 fault code.
module hall_sequence_generator #(
  parameter int CNT_W = 16,
  parameter int POS_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             dir,
  input  logic [CNT_W-1:0] step_period,
  input  logic             step_req,
  input  logic             fault_inject,
  output logic [2:0]       hall,
  output logic             step_strobe,
  output logic [POS_W-1:0] position
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);
  localparam logic [2:0]       IDX_LAST = 3'd5;

  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       hall_q, hall_d;
  logic             step_strobe_q, step_strobe_d;
  logic [POS_W-1:0] position_q, position_d;
  logic             step;
  logic [CNT_W-1:0] last_cnt;

  function automatic logic [2:0] code_of(input logic [2:0] idx);
    case (idx)
      3'd0:    code_of = 3'b101;
      3'd1:    code_of = 3'b100;
      3'd2:    code_of = 3'b110;
      3'd3:    code_of = 3'b010;
      3'd4:    code_of = 3'b011;
      3'd5:    code_of = 3'b001;
      default: code_of = 3'b101;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q         <= 3'd0;
      cnt_q         <= '0;
      hall_q        <= 3'b101;
      step_strobe_q <= 1'b0;
      position_q    <= '0;
    end else begin
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      hall_q        <= hall_d;
      step_strobe_q <= step_strobe_d;
      position_q    <= position_d;
    end
  end

  // Period is compared live, so lowering it below the running count steps on the next enabled cycle.
  assign last_cnt = step_period - CNT_ONE;

  // Next-state logic: step decision, timer, index and position
  always_comb begin
    step       = 1'b0;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    position_d = position_q;

    if (step_period == '0) begin
      cnt_d = '0;
      step  = enable & step_req;
    end else if (enable) begin
      if (cnt_q >= last_cnt) begin
        cnt_d = '0;
        step  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end

    if (step) begin
      if (dir) begin
        idx_d      = (idx_q == 3'd0) ? IDX_LAST : idx_q - 3'd1;
        position_d = position_q - POS_ONE;
      end else begin
        idx_d      = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        position_d = position_q + POS_ONE;
      end
    end
  end

  // Output logic: the fault code masks the hall lines only, the sequence keeps running underneath
  always_comb begin
    hall_d        = fault_inject ? 3'b111 : code_of(idx_d);
    step_strobe_d = step;
  end

  assign hall        = hall_q;
  assign step_strobe = step_strobe_q;
  assign position    = position_q;

endmodule

// File: tb/tb_hall_sequence_generator.sv
// Bench for hall_sequence_generator: directed scenarios against hand-derived constants
// plus a randomized run against an arithmetic reference model.
module tb_hall_sequence_generator;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        dir;
  logic [15:0] step_period;
  logic        step_req;
  logic        fault_inject;
  logic [2:0]  hall;
  logic        step_strobe;
  logic [15:0] position;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [2:0] seq [0:5] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

  // Reference model state, advanced once per clock in tick()
  int         m_idx;
  int         m_cnt;
  int         m_pos;
  logic       m_strobe;
  logic [2:0] m_hall;

  hall_sequence_generator #(.CNT_W(16), .POS_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .dir          (dir),
    .step_period  (step_period),
    .step_req     (step_req),
    .fault_inject (fault_inject),
    .hall         (hall),
    .step_strobe  (step_strobe),
    .position     (position)
  );

  always #5 clk = ~clk;

  // Advance the model from the inputs currently applied, then clock the DUT and settle
  task automatic tick();
    int p;
    bit stp;
    p   = int'(step_period);
    stp = 1'b0;
    if (rst) begin
      m_idx = 0; m_cnt = 0; m_pos = 0;
    end else begin
      if (p == 0) begin
        m_cnt = 0;
        stp   = enable && step_req;
      end else if (enable) begin
        if (m_cnt >= p - 1) begin
          m_cnt = 0;
          stp   = 1'b1;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
      if (stp) begin
        m_idx = (m_idx + (dir ? 5 : 1)) % 6;
        m_pos = (m_pos + (dir ? -1 : 1)) & 32'hFFFF;
      end
    end
    m_strobe = stp;
    m_hall   = (fault_inject && !rst) ? 3'b111 : seq[m_idx];
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    enable = 1'b1; dir = 1'b0; step_period = 16'd1; step_req = 1'b1; fault_inject = 1'b1;
    do_reset();
    tests_run++;
    if (hall !== 3'b101 || step_strobe !== 1'b0 || position !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got hall=%b strobe=%b pos=%h expected hall=101 strobe=0 pos=0000",
               hall, step_strobe, position);
    end
  endtask

  task automatic test_forward();
    logic [2:0]  exp_hall;
    logic [15:0] exp_pos;
    logic        exp_strobe;
    enable = 1'b1; dir = 1'b0; step_period = 16'd4; step_req = 1'b0; fault_inject = 1'b0;
    do_reset();
    for (int n = 1; n <= 24; n++) begin
      tick();
      exp_hall   = seq[(n / 4) % 6];
      exp_pos    = 16'(n / 4);
      exp_strobe = (n % 4 == 0);
      tests_run++;
      if (hall !== exp_hall || position !== exp_pos || step_strobe !== exp_strobe) begin
        tests_failed++;
        $display("[TB] FAIL forward_p4 cycle %0d: got hall=%b pos=%h strobe=%b expected hall=%b pos=%h strobe=%b",
                 n, hall, position, step_strobe, exp_hall, exp_pos, exp_strobe);
      end
    end
  endtask

  task automatic test_reverse();
    int          steps;
    logic [2:0]  exp_hall;
    logic [15:0] exp_pos;
    enable = 1'b1; dir = 1'b1; step_period = 16'd2; step_req = 1'b0; fault_inject = 1'b0;
    do_reset();
    for (int n = 1; n <= 8; n++) begin
      tick();
      steps    = n / 2;
      exp_hall = seq[(6 - (steps % 6)) % 6];
      exp_pos  = 16'(-steps);
      tests_run++;
      if (hall !== exp_hall || position !== exp_pos) begin
        tests_failed++;
        $display("[TB] FAIL reverse_p2 cycle %0d: got hall=%b pos=%h expected hall=%b pos=%h",
                 n, hall, position, exp_hall, exp_pos);
      end
    end
  endtask

  task automatic test_manual();
    enable = 1'b1; dir = 1'b0; step_period = 16'd0; step_req = 1'b0; fault_inject = 1'b0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step_req = 1'b1; tick();
      tests_run++;
      if (step_strobe !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL manual_strobe pulse %0d: got %b expected 1", k, step_strobe);
      end
      step_req = 1'b0; tick();
    end
    tests_run++;
    if (hall !== 3'b010 || position !== 16'd3) begin
      tests_failed++;
      $display("[TB] FAIL manual_pulses: got hall=%b pos=%h expected hall=010 pos=0003", hall, position);
    end
    step_req = 1'b1; tick(); tick();
    step_req = 1'b0;
    tests_run++;
    if (hall !== 3'b001 || position !== 16'd5) begin
      tests_failed++;
      $display("[TB] FAIL manual_held: got hall=%b pos=%h expected hall=001 pos=0005", hall, position);
    end
  endtask

  task automatic test_enable_hold();
    enable = 1'b1; dir = 1'b0; step_period = 16'd10; step_req = 1'b0; fault_inject = 1'b0;
    do_reset();
    repeat (6) tick();
    enable = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      tests_run++;
      if (hall !== 3'b101 || step_strobe !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL enable_hold cycle %0d: got hall=%b strobe=%b expected hall=101 strobe=0",
                 n, hall, step_strobe);
      end
    end
    enable = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (hall !== 3'b101) begin
      tests_failed++;
      $display("[TB] FAIL resume_early: got hall=%b expected 101", hall);
    end
    tick();
    tests_run++;
    if (hall !== 3'b100 || step_strobe !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL resume_step: got hall=%b strobe=%b expected hall=100 strobe=1", hall, step_strobe);
    end
  endtask

  task automatic test_period_lower();
    enable = 1'b1; dir = 1'b0; step_period = 16'd10; step_req = 1'b0; fault_inject = 1'b0;
    do_reset();
    repeat (6) tick();
    step_period = 16'd3;
    tick();
    tests_run++;
    if (hall !== 3'b100 || step_strobe !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL period_lower: got hall=%b strobe=%b expected hall=100 strobe=1", hall, step_strobe);
    end
  endtask

  task automatic test_fault();
    int strobes;
    enable = 1'b1; dir = 1'b0; step_period = 16'd3; step_req = 1'b0; fault_inject = 1'b0;
    do_reset();
    strobes = 0;
    fault_inject = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      tick();
      if (step_strobe === 1'b1) strobes++;
      tests_run++;
      if (hall !== 3'b111) begin
        tests_failed++;
        $display("[TB] FAIL fault_code cycle %0d: got hall=%b expected 111", n, hall);
      end
    end
    tests_run++;
    if (strobes != 2) begin
      tests_failed++;
      $display("[TB] FAIL fault_strobes: got %0d expected 2", strobes);
    end
    fault_inject = 1'b0;
    tick();
    tests_run++;
    if (hall !== 3'b110 || position !== 16'd2) begin
      tests_failed++;
      $display("[TB] FAIL fault_release: got hall=%b pos=%h expected hall=110 pos=0002", hall, position);
    end
  endtask

  task automatic test_reset_midcount();
    enable = 1'b1; dir = 1'b0; step_period = 16'd5; step_req = 1'b0; fault_inject = 1'b0;
    do_reset();
    repeat (8) tick();
    fault_inject = 1'b1;
    do_reset();
    tests_run++;
    if (hall !== 3'b101 || position !== 16'd0 || step_strobe !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_midcount: got hall=%b pos=%h strobe=%b expected hall=101 pos=0000 strobe=0",
               hall, position, step_strobe);
    end
    fault_inject = 1'b0;
    repeat (4) tick();
    tests_run++;
    if (hall !== 3'b101 || step_strobe !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL restart_early: got hall=%b strobe=%b expected hall=101 strobe=0", hall, step_strobe);
    end
    tick();
    tests_run++;
    if (hall !== 3'b100 || step_strobe !== 1'b1 || position !== 16'd1) begin
      tests_failed++;
      $display("[TB] FAIL restart_step: got hall=%b strobe=%b pos=%h expected hall=100 strobe=1 pos=0001",
               hall, step_strobe, position);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst          = ($urandom_range(0, 99) < 2);
      enable       = ($urandom_range(0, 9) < 8);
      dir          = $urandom_range(0, 1);
      step_req     = $urandom_range(0, 1);
      fault_inject = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 9) < 2) step_period = 16'($urandom_range(0, 6));
      tick();
      tests_run++;
      if (hall !== m_hall || step_strobe !== m_strobe || position !== 16'(m_pos)) begin
        tests_failed++;
        $display("[TB] FAIL random cycle %0d: got hall=%b strobe=%b pos=%h expected hall=%b strobe=%b pos=%h",
                 n, hall, step_strobe, position, m_hall, m_strobe, 16'(m_pos));
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; dir = 1'b0; step_period = 16'd0; step_req = 1'b0; fault_inject = 1'b0;
    m_idx = 0; m_cnt = 0; m_pos = 0; m_strobe = 1'b0; m_hall = 3'b101;
    #2;
    test_reset();
    test_forward();
    test_reverse();
    test_manual();
    test_enable_hold();
    test_period_lower();
    test_fault();
    test_reset_midcount();
    step_period = 16'd2;
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
